// File: rtl/rx_data_field_tracker_pkg.sv
// Shared types and constants for the receive data-field tracker.
// FSM encodings, byte geometry of a data word and the FCS-spill helper.
package rx_data_field_tracker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int FCS_BYTES  = 4;
  localparam int WORD_BYTES = 8;

  // True when the FCS following the data-field tail no longer fits in the same word.
  function automatic logic fcs_spills(input logic [2:0] bytes_more);
    return (int'(bytes_more) + FCS_BYTES) > WORD_BYTES;
  endfunction

endpackage

// File: rtl/rx_keep_mask_gen.sv
// Partial byte-keep mask for the last true-data word: the low i_rem bytes are kept.
// Purely combinational, no backpressure.
module rx_keep_mask_gen
  import rx_data_field_tracker_pkg::*;
(
  input  logic [2:0]            i_rem,
  output logic [WORD_BYTES-1:0] o_mask
);

  assign o_mask = (8'h01 << i_rem) - 8'h01;

endmodule

// File: rtl/rx_data_field_tracker.sv
// Walks data-field words after L/T decode, emitting per-word byte-keep (pad/FCS stripped) and length checks.
// Outputs are registered one cycle after each word; the word stream cannot be stalled, so there is no backpressure.
module rx_data_field_tracker
  import rx_data_field_tracker_pkg::*;
#(
  parameter int CNT_W = 13
) (
  input  logic             rxclk,
  input  logic             reset,
  input  logic             lt_valid,
  input  logic [CNT_W-1:0] integer_cnt,
  input  logic [2:0]       bits_more,
  input  logic [CNT_W-1:0] small_integer_cnt,
  input  logic [2:0]       small_bits_more,
  input  logic             small_frame,
  input  logic             len_invalid,
  input  logic             word_valid,
  input  logic             frame_end,
  output logic             keep_valid,
  output logic [7:0]       data_keep,
  output logic             field_end,
  output logic             frame_done,
  output logic             len_error,
  output logic             abort_frame,
  output logic [CNT_W-1:0] pad_word_cnt
);

  state_t           r_state;
  logic [CNT_W-1:0] r_true_words;
  logic [2:0]       r_true_rem;
  logic [CNT_W:0]   r_last_idx;
  logic             r_inval;
  logic             r_small;
  logic [CNT_W-1:0] r_widx;

  logic [WORD_BYTES-1:0] w_rem_mask;
  logic                  w_sat;
  logic                  w_in_full;
  logic                  w_partial;
  logic                  w_last_full;
  logic                  w_empty;
  logic                  w_past_data;
  logic [7:0]            w_keep;
  logic                  w_field_end;
  logic                  w_at_last;
  logic [CNT_W:0]        w_next_last_idx;

  rx_keep_mask_gen u_mask (
    .i_rem  (r_true_rem),
    .o_mask (w_rem_mask)
  );

  assign w_sat       = &r_widx;
  assign w_in_full   = r_widx < r_true_words;
  assign w_partial   = (r_true_rem != 3'd0) && (r_widx == r_true_words);
  assign w_last_full = (r_true_rem == 3'd0) && (r_true_words != '0) &&
                       (r_widx == r_true_words - CNT_W'(1));
  // A frame with no true data still reports its field end on word 0.
  assign w_empty     = (r_true_rem == 3'd0) && (r_true_words == '0) && (r_widx == '0);
  assign w_past_data = !w_in_full && !w_partial && !w_empty;

  assign w_keep      = r_inval   ? 8'h00 :
                       w_in_full ? 8'hFF :
                       w_partial ? w_rem_mask : 8'h00;
  assign w_field_end = !r_inval && (w_partial || w_last_full || w_empty);
  assign w_at_last   = ({1'b0, r_widx} == r_last_idx);

  assign w_next_last_idx = {1'b0, integer_cnt} + {{CNT_W{1'b0}}, fcs_spills(bits_more)};

  always_ff @(posedge rxclk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_true_words <= '0;
      r_true_rem   <= '0;
      r_last_idx   <= '0;
      r_inval      <= 1'b0;
      r_small      <= 1'b0;
      r_widx       <= '0;
      pad_word_cnt <= '0;
      keep_valid   <= 1'b0;
      data_keep    <= 8'h00;
      field_end    <= 1'b0;
      frame_done   <= 1'b0;
      len_error    <= 1'b0;
      abort_frame  <= 1'b0;
    end else begin
      keep_valid  <= 1'b0;
      data_keep   <= 8'h00;
      field_end   <= 1'b0;
      frame_done  <= 1'b0;
      len_error   <= 1'b0;
      abort_frame <= 1'b0;

      if (lt_valid) begin
        // A new L/T decode closes out whatever frame was still open as a length error.
        if (r_state != ST_IDLE) begin
          frame_done  <= 1'b1;
          len_error   <= 1'b1;
          abort_frame <= r_inval;
        end
        r_true_words <= small_integer_cnt;
        r_true_rem   <= small_bits_more;
        r_last_idx   <= w_next_last_idx;
        r_inval      <= len_invalid;
        r_small      <= small_frame;
        r_widx       <= '0;
        pad_word_cnt <= '0;
        r_state      <= ST_TRACK;
      end else begin
        case (r_state)
          ST_TRACK: begin
            if (word_valid) begin
              keep_valid <= 1'b1;
              data_keep  <= w_keep;
              field_end  <= w_field_end;
              if (!w_sat) begin
                r_widx <= r_widx + CNT_W'(1);
              end
              if (r_small && !r_inval && w_past_data) begin
                pad_word_cnt <= pad_word_cnt + CNT_W'(1);
              end
              if (frame_end) begin
                frame_done  <= 1'b1;
                len_error   <= !w_at_last || w_sat;
                abort_frame <= r_inval;
                r_state     <= ST_DONE;
              end
            end
          end
          ST_DONE: r_state <= ST_IDLE;
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
